// File: rtl/ifu_prefetch.sv
// Instruction prefetch stage: issues 4-byte fetches, queues the returned bytes and presents up to 4 head bytes to decode.
// Optional IFU_PERF_EN adds a saturating stall_cnt output counting cycles with no bytes available to decode.
module ifu_prefetch #(
  parameter int          DEPTH    = 8,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_busy,
  output logic [15:0] a,
  output logic        re,
  input  logic [7:0]  q0,
  input  logic [7:0]  q1,
  input  logic [7:0]  q2,
  input  logic [7:0]  q3,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [31:0] dec_bytes,
  output logic [2:0]  dec_avail,
  output logic [15:0] dec_pc,
  input  logic [2:0]  dec_take
`ifdef IFU_PERF_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    buf_q [DEPTH];
  logic [7:0]    q_lane [4];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [15:0]   fetch_pc;
  logic          vld_p1;
  logic          pop_ok;
  logic [CW-1:0] pop_n;
  logic [CW:0]   committed;

  assign q_lane[0] = q0;
  assign q_lane[1] = q1;
  assign q_lane[2] = q2;
  assign q_lane[3] = q3;

  // Space already claimed by queued bytes plus the response still on its way back.
  always_comb begin
    committed = {1'b0, count} + (vld_p1 ? (CW+1)'(4) : '0);
    re        = !rst && !redirect && !mem_busy && (committed <= (CW+1)'(DEPTH - 4));
    a         = fetch_pc;
    dec_avail = (count >= CW'(4)) ? 3'd4 : 3'(count);
    pop_ok    = (dec_take <= dec_avail);
    pop_n     = pop_ok ? CW'(dec_take) : '0;
    dec_bytes = '0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < dec_avail)
        dec_bytes[8*i +: 8] = buf_q[rd_ptr + PW'(i)];
    end
  end

  // Stage p0 -> p1: fetch issue; vld_p1 marks a response landing next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fetch_pc <= RESET_PC;
      dec_pc   <= RESET_PC;
      vld_p1   <= 1'b0;
    end else if (redirect) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fetch_pc <= redirect_pc;
      dec_pc   <= redirect_pc;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= re;
      if (re)
        fetch_pc <= fetch_pc + 16'd4;
      if (vld_p1)
        wr_ptr <= wr_ptr + PW'(4);
      rd_ptr <= rd_ptr + PW'(pop_n);
      count  <= count + (vld_p1 ? CW'(4) : '0) - pop_n;
      dec_pc <= dec_pc + 16'(pop_n);
    end
  end

  // Stage p1: response capture into the byte queue.
  always_ff @(posedge clk) begin
    if (vld_p1 && !redirect) begin
      for (int i = 0; i < 4; i++)
        buf_q[wr_ptr + PW'(i)] <= q_lane[i];
    end
  end

`ifdef IFU_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (dec_avail == 3'd0 && !redirect && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch: two instances (RESET_PC 0000 and FFFE), each with a one-cycle-latency memory model.
module tb_ifu_prefetch;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Memory contents: byte at addr is {n,n} with n = addr[3:0]+1 (0000->11, 0001->22, ...).
  function automatic logic [7:0] mem_byte(input logic [15:0] ad);
    logic [3:0] n;
    n = ad[3:0] + 4'd1;
    return {n, n};
  endfunction

  logic        mem_busy_1, re_1, redirect_1;
  logic [15:0] a_1, redirect_pc_1, dec_pc_1, pa1;
  logic [7:0]  q0_1, q1_1, q2_1, q3_1;
  logic [31:0] dec_bytes_1;
  logic [2:0]  dec_avail_1, dec_take_1;

  logic        mem_busy_2, re_2, redirect_2;
  logic [15:0] a_2, redirect_pc_2, dec_pc_2, pa2;
  logic [7:0]  q0_2, q1_2, q2_2, q3_2;
  logic [31:0] dec_bytes_2;
  logic [2:0]  dec_avail_2, dec_take_2;

`ifdef IFU_PERF_EN
  logic [15:0] stall_cnt_1, stall_cnt_2;
`endif

  ifu_prefetch #(.DEPTH(8), .RESET_PC(16'h0000)) u1 (
    .clk(clk), .rst(rst), .mem_busy(mem_busy_1), .a(a_1), .re(re_1),
    .q0(q0_1), .q1(q1_1), .q2(q2_1), .q3(q3_1),
    .redirect(redirect_1), .redirect_pc(redirect_pc_1),
    .dec_bytes(dec_bytes_1), .dec_avail(dec_avail_1), .dec_pc(dec_pc_1), .dec_take(dec_take_1)
`ifdef IFU_PERF_EN
    , .stall_cnt(stall_cnt_1)
`endif
  );

  ifu_prefetch #(.DEPTH(8), .RESET_PC(16'hFFFE)) u2 (
    .clk(clk), .rst(rst), .mem_busy(mem_busy_2), .a(a_2), .re(re_2),
    .q0(q0_2), .q1(q1_2), .q2(q2_2), .q3(q3_2),
    .redirect(redirect_2), .redirect_pc(redirect_pc_2),
    .dec_bytes(dec_bytes_2), .dec_avail(dec_avail_2), .dec_pc(dec_pc_2), .dec_take(dec_take_2)
`ifdef IFU_PERF_EN
    , .stall_cnt(stall_cnt_2)
`endif
  );

  // Memory responders: latch the fetch address on re, return bytes the following cycle.
  initial begin
    pa1 = 16'h0000;
    pa2 = 16'h0000;
  end
  always @(posedge clk) begin
    if (re_1) pa1 <= a_1;
    if (re_2) pa2 <= a_2;
  end
  assign q0_1 = mem_byte(pa1);
  assign q1_1 = mem_byte(pa1 + 16'd1);
  assign q2_1 = mem_byte(pa1 + 16'd2);
  assign q3_1 = mem_byte(pa1 + 16'd3);
  assign q0_2 = mem_byte(pa2);
  assign q1_2 = mem_byte(pa2 + 16'd1);
  assign q2_2 = mem_byte(pa2 + 16'd2);
  assign q3_2 = mem_byte(pa2 + 16'd3);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    mem_busy_1 = 1'b0; redirect_1 = 1'b0; redirect_pc_1 = 16'h0000; dec_take_1 = 3'd0;
    mem_busy_2 = 1'b1; redirect_2 = 1'b0; redirect_pc_2 = 16'h0000; dec_take_2 = 3'd0;
    step();
    step();
    chk("rst_avail", 32'(dec_avail_1), 32'd0);
    chk("rst_bytes", dec_bytes_1, 32'h0);
    chk("rst_pc", 32'(dec_pc_1), 32'h0000);
    chk("rst_re", 32'(re_1), 32'd0);
    chk("rst_a", 32'(a_1), 32'h0000);
    chk("rst_a2", 32'(a_2), 32'hFFFE);
    chk("rst_pc2", 32'(dec_pc_2), 32'hFFFE);

    rst = 1'b0;
    #1;
    chk("c1_re", 32'(re_1), 32'd1);
    chk("c1_a", 32'(a_1), 32'h0000);
    chk("busy_re2_0", 32'(re_2), 32'd0);

    step();  // E1
    chk("c2_re", 32'(re_1), 32'd1);
    chk("c2_a", 32'(a_1), 32'h0004);
    chk("c2_avail", 32'(dec_avail_1), 32'd0);
    chk("busy_re2_1", 32'(re_2), 32'd0);

    step();  // E2
    chk("c3_avail", 32'(dec_avail_1), 32'd4);
    chk("c3_bytes", dec_bytes_1, 32'h44332211);
    chk("c3_pc", 32'(dec_pc_1), 32'h0000);
    chk("c3_re", 32'(re_1), 32'd0);
    chk("busy_re2_2", 32'(re_2), 32'd0);

    step();  // E3
    chk("full_re", 32'(re_1), 32'd0);
    chk("full_bytes", dec_bytes_1, 32'h44332211);
    chk("busy_re2_3", 32'(re_2), 32'd0);

    step();  // E4
    chk("full_re2", 32'(re_1), 32'd0);
    chk("busy_re2_4", 32'(re_2), 32'd0);
    chk("busy_avail2", 32'(dec_avail_2), 32'd0);
    dec_take_1 = 3'd1;
    mem_busy_2 = 1'b0;
    #1;
    chk("unbusy_re2", 32'(re_2), 32'd1);
    chk("unbusy_a2", 32'(a_2), 32'hFFFE);

    step();  // E5
    chk("take1_bytes", dec_bytes_1, 32'h55443322);
    chk("take1_pc", 32'(dec_pc_1), 32'h0001);
    chk("take1_re", 32'(re_1), 32'd0);
    chk("wrap_re2", 32'(re_2), 32'd1);
    chk("wrap_a2", 32'(a_2), 32'h0002);
    dec_take_1 = 3'd3;

    step();  // E6
    chk("take3_bytes", dec_bytes_1, 32'h88776655);
    chk("take3_pc", 32'(dec_pc_1), 32'h0004);
    chk("take3_re", 32'(re_1), 32'd1);
    chk("take3_a", 32'(a_1), 32'h0008);
    chk("wrap_avail2", 32'(dec_avail_2), 32'd4);
    chk("wrap_bytes2", dec_bytes_2, 32'h221100FF);
    chk("wrap_pc2", 32'(dec_pc_2), 32'hFFFE);
    dec_take_1 = 3'd2;

    step();  // E7
    chk("take2_avail", 32'(dec_avail_1), 32'd2);
    chk("take2_bytes", dec_bytes_1, 32'h00008877);
    chk("take2_pc", 32'(dec_pc_1), 32'h0006);
    chk("take2_re", 32'(re_1), 32'd0);
    dec_take_1 = 3'd3;  // more than available: must be ignored

    step();  // E8
    chk("illegal_pc", 32'(dec_pc_1), 32'h0006);
    chk("illegal_avail", 32'(dec_avail_1), 32'd4);
    chk("ptrwrap_bytes", dec_bytes_1, 32'hAA998877);
    dec_take_1 = 3'd4;

    step();  // E9
    chk("drain_avail", 32'(dec_avail_1), 32'd2);
    chk("drain_bytes", dec_bytes_1, 32'h0000CCBB);
    chk("drain_pc", 32'(dec_pc_1), 32'h000A);
    chk("drain_re", 32'(re_1), 32'd1);
    chk("drain_a", 32'(a_1), 32'h000C);
    dec_take_1 = 3'd2;

    step();  // E10
    chk("empty_avail", 32'(dec_avail_1), 32'd0);
    chk("empty_bytes", dec_bytes_1, 32'h0);
    chk("empty_pc", 32'(dec_pc_1), 32'h000C);
    chk("empty_a", 32'(a_1), 32'h0010);
    dec_take_1 = 3'd0;

    step();  // E11
    chk("refill_bytes", dec_bytes_1, 32'h00FFEEDD);
    chk("refill_pc", 32'(dec_pc_1), 32'h000C);
    chk("refill_re", 32'(re_1), 32'd0);
    dec_take_1 = 3'd4;

    step();  // E12
    chk("pushpop_bytes", dec_bytes_1, 32'h44332211);
    chk("pushpop_pc", 32'(dec_pc_1), 32'h0010);
    chk("pushpop_a", 32'(a_1), 32'h0014);

    step();  // E13
    chk("steady_avail", 32'(dec_avail_1), 32'd0);
    chk("steady_pc", 32'(dec_pc_1), 32'h0014);
    chk("steady_a", 32'(a_1), 32'h0018);
    dec_take_1 = 3'd0;
    redirect_1 = 1'b1;
    redirect_pc_1 = 16'h1235;
    #1;
    chk("redir_re", 32'(re_1), 32'd0);

    step();  // E14
    redirect_1 = 1'b0;
    #1;
    chk("redir_avail", 32'(dec_avail_1), 32'd0);
    chk("redir_pc", 32'(dec_pc_1), 32'h1235);
    chk("redir_re1", 32'(re_1), 32'd1);
    chk("redir_a", 32'(a_1), 32'h1235);

    step();  // E15
    chk("redir_drop", 32'(dec_avail_1), 32'd0);
    chk("redir_a2", 32'(a_1), 32'h1239);

    step();  // E16
    chk("redir_bytes", dec_bytes_1, 32'h99887766);
    chk("redir_avail4", 32'(dec_avail_1), 32'd4);
    chk("redir_pc2", 32'(dec_pc_1), 32'h1235);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
